sobel_stream_filter: RTL and testbench

//  Streaming 3x3 Sobel edge filter for the camera pixel path, one pixel per accepted beat.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_stream_filter_line_buffer.sv | 45 ++++
 rtl/sobel_stream_filter.sv | 198 +++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types, kernel coefficients and width helper for the Sobel stream filter.
package sobel_pkg;

    typedef enum logic [1:0] {
        SOBEL_GX   = 2'd0,
        SOBEL_GY   = 2'd1,
        SOBEL_MAG  = 2'd2,
        SOBEL_PASS = 2'd3
    } sobel_mode_t;

    // Rows listed top (oldest line) to bottom (current line), columns left to right.
    localparam int KERNEL_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int KERNEL_GY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    // Signed gradients span +/-4*(2^dw-1); unsigned |Gx|+|Gy| spans 8*(2^dw-1).
    function automatic int out_width(input int dw);
        return dw + 3;
    endfunction

endpackage

// File: rtl/sobel_stream_filter_line_buffer.sv
// Clock-enabled delay line of DEPTH accepted beats, built on a circular RAM.
module line_buffer #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 640
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clken,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // The slot about to be overwritten holds the sample from DEPTH beats ago.
    assign o_dout = mem[ptr_q];

    // Advance the circular pointer on every accepted beat.
    always_comb begin
        ptr_d = ptr_q;
        if (i_clken) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register; RAM contents are deliberately left unreset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // RAM write port.
    always_ff @(posedge i_clk) begin
        if (i_clken) begin
            mem[ptr_q] <= i_din;
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter: S0 window/line buffers, S1 gradient sums, S2 abs/mode/border.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int  DATA_WIDTH = 12,
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    localparam int OUT_WIDTH  = out_width(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [1:0]            i_mode,
    input  logic                  i_val_valid,
    input  logic                  i_sof,
    input  logic [DATA_WIDTH-1:0] i_val,
    output logic                  o_val_valid,
    output logic                  o_sof,
    output logic [OUT_WIDTH-1:0]  o_val,
    output logic                  o_frame_err
);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    sobel_mode_t      mode_q, mode_d, mode_cur;
    logic             frame_err_q, frame_err_d;
    logic             sof_acc;
    pix_t             lb1_dout, lb2_dout;
    pix_t             win_q [3][3];
    pix_t             win_d [3][3];

    logic             v0_q, v0_d, sof0_q, sof0_d, border0_q, border0_d;
    sobel_mode_t      mode0_q, mode0_d;
    logic             v1_q, v1_d, sof1_q, sof1_d, border1_q, border1_d;
    sobel_mode_t      mode1_q, mode1_d;
    pix_t             centre1_q, centre1_d;
    logic signed [OUT_WIDTH-1:0] gx_q, gx_d, gy_q, gy_d;
    logic [OUT_WIDTH-1:0] abs_x, abs_y;
    logic             o_val_valid_q, o_val_valid_d, o_sof_q, o_sof_d;
    logic [OUT_WIDTH-1:0] o_val_q, o_val_d;

    line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_r1 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clken(i_val_valid),
        .i_din  (i_val),
        .o_dout (lb1_dout)
    );

    line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_r2 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_clken(i_val_valid),
        .i_din  (lb1_dout),
        .o_dout (lb2_dout)
    );

    // S0: position tracking, mode capture on sof, window shift and border tagging.
    always_comb begin
        sof_acc     = i_val_valid & i_sof;
        col_cur     = sof_acc ? '0 : col_q;
        row_cur     = sof_acc ? '0 : row_q;
        mode_cur    = sof_acc ? sobel_mode_t'(i_mode) : mode_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        frame_err_d = frame_err_q;
        win_d       = win_q;
        if (i_val_valid) begin
            mode_d = mode_cur;
            if (col_cur == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (row_cur == ROW_W'(IMG_HEIGHT - 1)) begin
                    row_d       = '0;
                    frame_err_d = 1'b1;
                end else begin
                    row_d = row_cur + ROW_W'(1);
                end
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
            // A new frame always clears the overrun, even if it arrives on a wrap.
            if (sof_acc) begin
                frame_err_d = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                win_d[i][0] = win_q[i][1];
                win_d[i][1] = win_q[i][2];
            end
            win_d[0][2] = lb2_dout;
            win_d[1][2] = lb1_dout;
            win_d[2][2] = i_val;
        end
        v0_d      = i_val_valid;
        sof0_d    = sof_acc;
        border0_d = (row_cur < ROW_W'(2)) || (col_cur < COL_W'(2));
        mode0_d   = mode_cur;
    end

    // S1: signed gradient sums from the window; mode travels with each beat so
    // the tail of one frame is unaffected by the next frame's mode.
    always_comb begin
        int acc_x;
        int acc_y;
        acc_x = 0;
        acc_y = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc_x = acc_x + KERNEL_GX[i][j] * int'(win_q[i][j]);
                acc_y = acc_y + KERNEL_GY[i][j] * int'(win_q[i][j]);
            end
        end
        gx_d      = OUT_WIDTH'(acc_x);
        gy_d      = OUT_WIDTH'(acc_y);
        centre1_d = win_q[1][1];
        v1_d      = v0_q;
        sof1_d    = sof0_q;
        border1_d = border0_q;
        mode1_d   = mode0_q;
    end

    // S2: magnitude, mode select and border mask.
    always_comb begin
        abs_x         = gx_q[OUT_WIDTH-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        abs_y         = gy_q[OUT_WIDTH-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        o_val_valid_d = v1_q;
        o_sof_d       = sof1_q;
        o_val_d       = '0;
        if (v1_q && !border1_q) begin
            case (mode1_q)
                SOBEL_GX:   o_val_d = abs_x;
                SOBEL_GY:   o_val_d = abs_y;
                SOBEL_MAG:  o_val_d = abs_x + abs_y;
                SOBEL_PASS: o_val_d = OUT_WIDTH'(centre1_q);
                default:    o_val_d = '0;
            endcase
        end
    end

    // Pipeline and control registers; reset flushes every stage.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            mode_q        <= SOBEL_GX;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            v0_q          <= 1'b0;
            sof0_q        <= 1'b0;
            border0_q     <= 1'b1;
            mode0_q       <= SOBEL_GX;
            v1_q          <= 1'b0;
            sof1_q        <= 1'b0;
            border1_q     <= 1'b1;
            mode1_q       <= SOBEL_GX;
            centre1_q     <= '0;
            gx_q          <= '0;
            gy_q          <= '0;
            o_val_valid_q <= 1'b0;
            o_sof_q       <= 1'b0;
            o_val_q       <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            mode_q        <= mode_d;
            frame_err_q   <= frame_err_d;
            win_q         <= win_d;
            v0_q          <= v0_d;
            sof0_q        <= sof0_d;
            border0_q     <= border0_d;
            mode0_q       <= mode0_d;
            v1_q          <= v1_d;
            sof1_q        <= sof1_d;
            border1_q     <= border1_d;
            mode1_q       <= mode1_d;
            centre1_q     <= centre1_d;
            gx_q          <= gx_d;
            gy_q          <= gy_d;
            o_val_valid_q <= o_val_valid_d;
            o_sof_q       <= o_sof_d;
            o_val_q       <= o_val_d;
        end
    end

    assign o_val_valid = o_val_valid_q;
    assign o_sof       = o_sof_q;
    assign o_val       = o_val_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x6 frame of 8-bit pixels.
module tb_sobel_stream_filter;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int OW = DW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    i_mode = '0;
    logic          i_val_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic [DW-1:0] i_val = '0;
    logic          o_val_valid;
    logic          o_sof;
    logic [OW-1:0] o_val;
    logic          o_frame_err;

    sobel_stream_filter #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_mode     (i_mode),
        .i_val_valid(i_val_valid),
        .i_sof      (i_sof),
        .i_val      (i_val),
        .o_val_valid(o_val_valid),
        .o_sof      (o_sof),
        .o_val      (o_val),
        .o_frame_err(o_frame_err)
    );

    always #5 clk = ~clk;

    // Frame vector: pattern, mode, gaps, value inside region [rlo..rhi]x[clo..chi]
    // (zero elsewhere), or passthrough of the centre pixel.
    typedef struct {
        int pat; int mode; bit gaps; int exp_in;
        int rlo; int rhi; int clo; int chi; bit pass;
    } vec_t;
    typedef struct { int val; bit sof; int due; } exp_t;

    vec_t vecs [14];
    exp_t q [$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0: return 77;
            1: return (c >= 4) ? 100 : 0;
            2: return (r >= 4) ? 50 : 0;
            3: return r * 10 + c;
            4: return (c < 4) ? 100 : 0;
            5: return (c >= 4) ? 255 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_of(input vec_t v, input int r, input int c);
        if (r < 2 || c < 2) return 0;
        if (v.pass) return pix(v.pat, r - 1, c - 1);
        if (r >= v.rlo && r <= v.rhi && c >= v.clo && c <= v.chi) return v.exp_in;
        return 0;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, got, want, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (o_val_valid) begin
            n_tests++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out: got val=%0d sof=%0b, want no output (cyc %0d)",
                         o_val, o_sof, cyc);
            end else begin
                e = q.pop_front();
                if (int'(o_val) != e.val || o_sof != e.sof || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL out_beat: got val=%0d sof=%0b at cyc %0d, want val=%0d sof=%0b at cyc %0d",
                             o_val, o_sof, cyc, e.val, e.sof, e.due);
                end
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_out: got no output at cyc %0d, want val=%0d due cyc %0d",
                     cyc, q[0].val, q[0].due);
            void'(q.pop_front());
        end
    endtask

    task automatic step(input bit v, input bit s, input logic [1:0] m, input int px,
                        input int ev, input bit es);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        i_val_valid = v;
        i_sof       = s;
        i_mode      = m;
        i_val       = DW'(px);
        if (v) begin
            e.val = ev;
            e.sof = es;
            e.due = cyc + 3;
            q.push_back(e);
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 0, 0, 1'b0);
    endtask

    task automatic drive_px(input vec_t v, input int r, input int c, input bit s);
        logic [1:0] m;
        m = s ? 2'(v.mode) : 2'($urandom_range(0, 3));
        step(1'b1, s, m, pix(v.pat, r, c), exp_of(v, r, c), s);
    endtask

    task automatic run_frame(input vec_t v);
        for (int k = 0; k < W * H; k++) begin
            if (v.gaps && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
            drive_px(v, k / W, k % W, k == 0);
            if (k == 1) chk("err_cleared_by_sof", int'(o_frame_err), 0);
        end
    endtask

    initial begin
        vec_t va;
        vec_t vb;
        vecs[0]  = '{0, 2, 1'b0, 0,    2, 5, 2, 7, 1'b0};
        vecs[1]  = '{1, 0, 1'b0, 400,  2, 5, 4, 5, 1'b0};
        vecs[2]  = '{1, 1, 1'b0, 0,    2, 5, 2, 7, 1'b0};
        vecs[3]  = '{2, 1, 1'b0, 200,  4, 5, 2, 7, 1'b0};
        vecs[4]  = '{2, 2, 1'b0, 200,  4, 5, 2, 7, 1'b0};
        vecs[5]  = '{3, 0, 1'b0, 8,    2, 5, 2, 7, 1'b0};
        vecs[6]  = '{3, 1, 1'b0, 80,   2, 5, 2, 7, 1'b0};
        vecs[7]  = '{3, 2, 1'b0, 88,   2, 5, 2, 7, 1'b0};
        vecs[8]  = '{3, 3, 1'b0, 0,    2, 5, 2, 7, 1'b1};
        vecs[9]  = '{4, 0, 1'b0, 400,  2, 5, 4, 5, 1'b0};
        vecs[10] = '{5, 2, 1'b0, 1020, 2, 5, 4, 5, 1'b0};
        vecs[11] = '{1, 0, 1'b1, 400,  2, 5, 4, 5, 1'b0};
        vecs[12] = '{3, 2, 1'b1, 88,   2, 5, 2, 7, 1'b0};
        vecs[13] = '{3, 3, 1'b1, 0,    2, 5, 2, 7, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", int'(o_val_valid), 0);
        chk("reset_sof", int'(o_sof), 0);
        chk("reset_val", int'(o_val), 0);
        chk("reset_err", int'(o_frame_err), 0);

        // Back-to-back frames from the vector table.
        for (int i = 0; i < 14; i++) run_frame(vecs[i]);
        idle(6);
        chk("queue_drained", q.size(), 0);
        chk("err_after_full_frame", int'(o_frame_err), 1);

        // Early sof at (3,5): frame B restarts with a new mode, then runs 7 lines.
        va = vecs[5];
        vb = vecs[6];
        for (int k = 0; k < 3 * W + 5; k++) drive_px(va, k / W, k % W, k == 0);
        chk("err_mid_frame", int'(o_frame_err), 0);
        for (int k = 0; k < 7 * W; k++) begin
            if (k < W * H) drive_px(vb, k / W, k % W, k == 0);
            else step(1'b1, 1'b0, 2'($urandom_range(0, 3)), pix(3, k / W, k % W), 0, 1'b0);
            if (k == 1) chk("err_after_early_sof", int'(o_frame_err), 0);
            if (k == W * H - 1) chk("err_before_wrap", int'(o_frame_err), 0);
            if (k == W * H) chk("err_on_wrap", int'(o_frame_err), 1);
        end
        chk("err_sticky", int'(o_frame_err), 1);
        run_frame(vecs[0]);
        idle(6);
        chk("queue_drained_2", q.size(), 0);

        // Reset mid-line with the pipeline full.
        for (int k = 0; k < 3 * W + 6; k++) drive_px(vecs[7], k / W, k % W, k == 0);
        @(posedge clk);
        #1;
        i_val_valid = 1'b0;
        chk("pipe_full_valid", int'(o_val_valid), 1);
        chk("pipe_full_val", int'(o_val), 88);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(o_val_valid), 0);
        chk("midrst_sof", int'(o_sof), 0);
        chk("midrst_val", int'(o_val), 0);
        chk("midrst_err", int'(o_frame_err), 0);
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            chk("no_spurious_valid", int'(o_val_valid), 0);
        end
        // No sof after reset: first pixel is (0,0) and mode stays |Gx| despite i_mode=3.
        for (int k = 0; k < W * H; k++) begin
            step(1'b1, 1'b0, (k == 0) ? 2'd3 : 2'($urandom_range(0, 3)),
                 pix(1, k / W, k % W), exp_of(vecs[1], k / W, k % W), 1'b0);
        end
        idle(6);
        chk("queue_drained_3", q.size(), 0);
        chk("err_after_reset_frame", int'(o_frame_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
